// File: rtl/fp_pkg.sv
// Shared IEEE 754 single-precision field constants, class codes and FIFO entry layout.
package fp_pkg;

  localparam int unsigned EXP_MSB  = 30;
  localparam int unsigned EXP_LSB  = 23;
  localparam int unsigned MAN_MSB  = 22;
  localparam int unsigned QNAN_BIT = 22;
  localparam int unsigned WORD_W   = 32;
  localparam logic [7:0]  EXP_MAX  = 8'hFF;
  localparam logic [31:0] CANON_QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    CLS_ZERO = 3'd0,
    CLS_SUB  = 3'd1,
    CLS_NORM = 3'd2,
    CLS_INF  = 3'd3,
    CLS_QNAN = 3'd4,
    CLS_SNAN = 3'd5
  } fp_class_t;

  typedef struct packed {
    logic [WORD_W-1:0] result;
    fp_class_t         cls;
    logic              invalid;
  } fp_entry_t;

endpackage

// File: rtl/fp_result_buffer_if.sv
// Producer/consumer bus of the result buffer, including debug counters.
interface fp_result_buffer_if
  import fp_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) ();

  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_a;
  logic [WORD_W-1:0] in_b;
  logic [WORD_W-1:0] in_result;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_result;
  fp_class_t         out_class;
  logic              out_invalid;
  logic [LVL_W-1:0]  level;
  logic              clr_counts;
  logic [CNT_W-1:0]  cnt_zero;
  logic [CNT_W-1:0]  cnt_inf;
  logic [CNT_W-1:0]  cnt_nan;
  logic [CNT_W-1:0]  cnt_invalid;

  // Producer, consumer and debug side (testbench / upstream logic)
  modport master (
    output in_valid, in_a, in_b, in_result, out_ready, clr_counts,
    input  in_ready, out_valid, out_result, out_class, out_invalid, level,
           cnt_zero, cnt_inf, cnt_nan, cnt_invalid
  );

  // Buffer side
  modport slave (
    input  in_valid, in_a, in_b, in_result, out_ready, clr_counts,
    output in_ready, out_valid, out_result, out_class, out_invalid, level,
           cnt_zero, cnt_inf, cnt_nan, cnt_invalid
  );

endinterface

// File: rtl/fp_classify.sv
// Combinational IEEE 754 single-precision class decoder.
module fp_classify
  import fp_pkg::*;
(
  input  logic [WORD_W-1:0] word_i,
  output fp_class_t         cls_o
);

  logic [7:0]       exp_w;
  logic [MAN_MSB:0] man_w;
  logic             unused_sign;

  assign exp_w       = word_i[EXP_MSB:EXP_LSB];
  assign man_w       = word_i[MAN_MSB:0];
  assign unused_sign = word_i[WORD_W-1];

  // Decode class from exponent/mantissa; sign does not affect the class
  always_comb begin
    cls_o = CLS_NORM;
    if (exp_w == 8'd0) begin
      cls_o = (man_w == '0) ? CLS_ZERO : CLS_SUB;
    end else if (exp_w == EXP_MAX) begin
      if (man_w == '0)         cls_o = CLS_INF;
      else if (man_w[QNAN_BIT]) cls_o = CLS_QNAN;
      else                     cls_o = CLS_SNAN;
    end
  end

endmodule

// File: rtl/fp_result_buffer.sv
// Capture FIFO for multiplier products with classification, invalid detection and event counters.
module fp_result_buffer
  import fp_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input logic               clk,
  input logic               rst,
  fp_result_buffer_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  fp_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [CNT_W-1:0] cnt_zero_q, cnt_zero_d;
  logic [CNT_W-1:0] cnt_inf_q, cnt_inf_d;
  logic [CNT_W-1:0] cnt_nan_q, cnt_nan_d;
  logic [CNT_W-1:0] cnt_inv_q, cnt_inv_d;

  fp_class_t res_cls, a_cls, b_cls;
  fp_entry_t wr_entry, head;
  logic      in_ready_c, out_valid_c, accept, pop, invalid_c;

  fp_classify u_cls_res (.word_i(bus.in_result), .cls_o(res_cls));
  fp_classify u_cls_a   (.word_i(bus.in_a),      .cls_o(a_cls));
  fp_classify u_cls_b   (.word_i(bus.in_b),      .cls_o(b_cls));

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Handshakes and invalid-operation detection from the operands
  always_comb begin
    in_ready_c  = (level_q != LVL_W'(DEPTH));
    out_valid_c = (level_q != LVL_W'(0));
    accept      = bus.in_valid && in_ready_c;
    pop         = out_valid_c && bus.out_ready;
    invalid_c   = (a_cls == CLS_INF  && b_cls == CLS_ZERO) ||
                  (a_cls == CLS_ZERO && b_cls == CLS_INF)  ||
                  (a_cls == CLS_SNAN) || (b_cls == CLS_SNAN);
    wr_entry    = '{result: bus.in_result, cls: res_cls, invalid: invalid_c};
    head        = mem_q[rd_ptr_q];
  end

  // Next-state for pointers, occupancy and saturating counters
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    cnt_zero_d = cnt_zero_q;
    cnt_inf_d  = cnt_inf_q;
    cnt_nan_d  = cnt_nan_q;
    cnt_inv_d  = cnt_inv_q;
    if (accept) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)    rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (accept && !pop)      level_d = level_q + LVL_W'(1);
    else if (pop && !accept) level_d = level_q - LVL_W'(1);
    if (bus.clr_counts) begin
      cnt_zero_d = '0;
      cnt_inf_d  = '0;
      cnt_nan_d  = '0;
      cnt_inv_d  = '0;
    end else if (accept) begin
      if (res_cls == CLS_ZERO) cnt_zero_d = sat_inc(cnt_zero_q);
      if (res_cls == CLS_INF)  cnt_inf_d  = sat_inc(cnt_inf_q);
      if (res_cls == CLS_QNAN || res_cls == CLS_SNAN) cnt_nan_d = sat_inc(cnt_nan_q);
      if (invalid_c)           cnt_inv_d  = sat_inc(cnt_inv_q);
    end
  end

  // Control state register; reset empties the buffer and clears counters
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      cnt_zero_q <= '0;
      cnt_inf_q  <= '0;
      cnt_nan_q  <= '0;
      cnt_inv_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      cnt_zero_q <= cnt_zero_d;
      cnt_inf_q  <= cnt_inf_d;
      cnt_nan_q  <= cnt_nan_d;
      cnt_inv_q  <= cnt_inv_d;
    end
  end

  // Entry storage; not reset, written only on a real accept
  always_ff @(posedge clk) begin
    if (!rst && accept) mem_q[wr_ptr_q] <= wr_entry;
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.out_valid   = out_valid_c;
  assign bus.out_result  = out_valid_c ? head.result  : '0;
  assign bus.out_class   = out_valid_c ? head.cls     : CLS_ZERO;
  assign bus.out_invalid = out_valid_c ? head.invalid : 1'b0;
  assign bus.level       = level_q;
  assign bus.cnt_zero    = cnt_zero_q;
  assign bus.cnt_inf     = cnt_inf_q;
  assign bus.cnt_nan     = cnt_nan_q;
  assign bus.cnt_invalid = cnt_inv_q;

endmodule

// File: tb/tb_fp_result_buffer.sv
// Directed plus randomized checks of fp_result_buffer against a queue-based reference model.
module tb_fp_result_buffer;
  import fp_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 2;
  localparam int          CMAX  = 3;

  typedef struct {
    logic [31:0] r;
    int          c;
    bit          inv;
  } ent_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  ent_t q[$];
  int   m_zero, m_inf, m_nan, m_inv;

  fp_result_buffer_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  fp_result_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not end, observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Class number from the IEEE fields: 0 zero,1 sub,2 norm,3 inf,4 qnan,5 snan
  function automatic int cls_of(input logic [31:0] w);
    int e, m;
    e = int'((w >> 23) & 32'hFF);
    m = int'(w & 32'h7F_FFFF);
    if (e == 0)   return (m == 0) ? 0 : 1;
    if (e != 255) return 2;
    if (m == 0)   return 3;
    return (m >= 32'h40_0000) ? 4 : 5;
  endfunction

  function automatic bit inv_of(input logic [31:0] a, input logic [31:0] b);
    int ca, cb;
    ca = cls_of(a);
    cb = cls_of(b);
    return (ca == 3 && cb == 0) || (ca == 0 && cb == 3) || ca == 5 || cb == 5;
  endfunction

  function automatic int sat(input int v);
    return (v < CMAX) ? v + 1 : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    chk({tag, ".level"},      32'(bus.level),       32'(n));
    chk({tag, ".in_ready"},   32'(bus.in_ready),    32'(n != DEPTH));
    chk({tag, ".out_valid"},  32'(bus.out_valid),   32'(n != 0));
    chk({tag, ".out_result"}, bus.out_result,       (n != 0) ? q[0].r : 32'h0);
    chk({tag, ".out_class"},  32'(bus.out_class),   (n != 0) ? 32'(q[0].c) : 32'h0);
    chk({tag, ".out_inv"},    32'(bus.out_invalid), (n != 0) ? 32'(q[0].inv) : 32'h0);
    chk({tag, ".cnt_zero"},   32'(bus.cnt_zero),    32'(m_zero));
    chk({tag, ".cnt_inf"},    32'(bus.cnt_inf),     32'(m_inf));
    chk({tag, ".cnt_nan"},    32'(bus.cnt_nan),     32'(m_nan));
    chk({tag, ".cnt_inv"},    32'(bus.cnt_invalid), 32'(m_inv));
  endtask

  // Advance the model with the currently driven inputs, clock once, then compare
  task automatic cycle(input string tag);
    bit   acc, pop;
    ent_t e;
    acc = bus.in_valid && (q.size() < DEPTH);
    pop = bus.out_ready && (q.size() > 0);
    if (rst) begin
      q.delete();
      m_zero = 0; m_inf = 0; m_nan = 0; m_inv = 0;
    end else begin
      e.r   = bus.in_result;
      e.c   = cls_of(bus.in_result);
      e.inv = inv_of(bus.in_a, bus.in_b);
      if (bus.clr_counts) begin
        m_zero = 0; m_inf = 0; m_nan = 0; m_inv = 0;
      end else if (acc) begin
        if (e.c == 0) m_zero = sat(m_zero);
        if (e.c == 3) m_inf  = sat(m_inf);
        if (e.c == 4 || e.c == 5) m_nan = sat(m_nan);
        if (e.inv)    m_inv  = sat(m_inv);
      end
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic drive(input bit v, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r);
    bus.in_valid  = v;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_result = r;
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] pool [9];
    int          k;
    pool = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000, CANON_QNAN,
             32'h7F80_0001, 32'h7FA0_0000, 32'h3F80_0000, 32'h0000_0001};
    k = int'($urandom_range(0, 11));
    return (k < 9) ? pool[k] : $urandom;
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    m_zero = 0; m_inf = 0; m_nan = 0; m_inv = 0;
    rst = 1'b1;
    drive(1'b0, '0, '0, '0);
    bus.out_ready  = 1'b0;
    bus.clr_counts = 1'b0;
    #1;
    cycle("reset0");
    cycle("reset1");
    chk("reset.level", 32'(bus.level), 32'h0);
    chk("reset.in_ready", 32'(bus.in_ready), 32'h1);
    rst = 1'b0;

    // Normal product into an empty buffer
    drive(1'b1, 32'h3F80_0000, 32'h4000_0000, 32'h4000_0000);
    cycle("normal");
    chk("normal.class", 32'(bus.out_class), 32'h2);
    chk("normal.valid", 32'(bus.out_valid), 32'h1);
    drive(1'b0, '0, '0, '0);
    bus.out_ready = 1'b1;
    cycle("normal.pop");
    bus.out_ready = 1'b0;

    // Inf x 0 gives invalid NaN; then a plain infinity
    drive(1'b1, 32'h7F80_0000, 32'h0000_0000, CANON_QNAN);
    cycle("infzero");
    chk("infzero.class", 32'(bus.out_class), 32'h4);
    chk("infzero.inv", 32'(bus.out_invalid), 32'h1);
    chk("infzero.cnt_nan", 32'(bus.cnt_nan), 32'h1);
    drive(1'b1, 32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000);
    cycle("inf");
    chk("inf.cnt_inf", 32'(bus.cnt_inf), 32'h1);
    drive(1'b0, '0, '0, '0);
    bus.out_ready = 1'b1;
    cycle("inf.pop0");
    chk("inf.head_class", 32'(bus.out_class), 32'h3);
    cycle("inf.pop1");
    bus.out_ready = 1'b0;

    // Fill to full, reject a fifth, drain in order
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 32'h3F80_0000, 32'h3F80_0000, 32'(i));
      cycle("fill");
    end
    chk("full.level", 32'(bus.level), 32'h4);
    chk("full.in_ready", 32'(bus.in_ready), 32'h0);
    drive(1'b1, 32'h3F80_0000, 32'h3F80_0000, 32'h5);
    cycle("full.reject");
    drive(1'b0, '0, '0, '0);
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain.order", bus.out_result, 32'(i));
      cycle("drain");
      if (i == 1) chk("drain.ready", 32'(bus.in_ready), 32'h1);
    end
    bus.out_ready = 1'b0;

    // Simultaneous accept and pop at level 2
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, '0, '0, 32'h10 + 32'(i));
      cycle("sim.prefill");
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, '0, '0, 32'h20 + 32'(i));
      cycle("sim.both");
      chk("sim.level", 32'(bus.level), 32'h2);
    end
    drive(1'b0, '0, '0, '0);
    cycle("sim.drain0");
    cycle("sim.drain1");

    // Counter saturation and clear priority
    bus.clr_counts = 1'b1;
    cycle("clr");
    bus.clr_counts = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, '0, '0, (i % 2 == 0) ? 32'h0000_0000 : 32'h8000_0000);
      cycle("sat");
    end
    chk("sat.cnt_zero", 32'(bus.cnt_zero), 32'h3);
    bus.clr_counts = 1'b1;
    drive(1'b1, '0, '0, 32'h0);
    cycle("clr.accept");
    chk("clr.cnt_zero", 32'(bus.cnt_zero), 32'h0);
    bus.clr_counts = 1'b0;
    drive(1'b0, '0, '0, '0);
    cycle("clr.drain");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), pick(), pick(), pick());
      bus.out_ready  = 1'($urandom_range(0, 2) == 0);
      bus.clr_counts = 1'($urandom_range(0, 40) == 0);
      rst            = 1'($urandom_range(0, 150) == 0);
      cycle("rand");
    end
    rst = 1'b0;
    bus.clr_counts = 1'b0;
    bus.out_ready  = 1'b1;
    drive(1'b0, '0, '0, '0);
    for (int i = 0; i < 4; i++) cycle("rand.drain");

    // Reset mid-operation with a handshake in the reset cycle
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h7F80_0000, 32'h0, 32'h7F80_0000);
      cycle("pre_rst");
    end
    chk("pre_rst.level", 32'(bus.level), 32'h3);
    rst = 1'b1;
    bus.out_ready = 1'b1;
    cycle("mid_rst");
    chk("mid_rst.level", 32'(bus.level), 32'h0);
    chk("mid_rst.out_result", bus.out_result, 32'h0);
    chk("mid_rst.cnt_inv", 32'(bus.cnt_invalid), 32'h0);
    rst = 1'b0;
    drive(1'b0, '0, '0, '0);
    cycle("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
